// File: rtl/lcd_menu_ctrl.sv
// HD44780 8-bit write-only menu controller: button-driven cursor/mode FSM, LED register, LCD init and redraw.
// Optional LCD_MENU_DEBOUNCE_EN puts a DEB_CYCLES stability filter on every button bit.
module lcd_menu_ctrl #(
  parameter int unsigned N_ITEMS    = 5,
  parameter int unsigned EN_CYCLES  = 25,
  parameter int unsigned CMD_WAIT   = 2000,
  parameter int unsigned CLR_WAIT   = 82000,
  parameter int unsigned PWRUP_WAIT = 750000,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [3:0]         btn,
  output logic [N_ITEMS-1:0] led_state,
  output logic               busy,
  output logic               LCD_RS,
  output logic               LCD_EN,
  output logic               LCD_RW,
  output logic [7:0]         LCD_DATA
);

  typedef enum logic [1:0] {S_PWR, S_INIT, S_IDLE, S_REDRAW} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_t;

  localparam logic [55:0] STR_ON   = "ACESO  ";
  localparam logic [55:0] STR_OFF  = "APAGADO";
  localparam logic [3:0]  LAST_CMD = 4'd3;
  localparam logic [3:0]  LAST_RD  = 4'd13;

  logic [3:0] w_btn;

`ifdef LCD_MENU_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  logic [3:0]    r_deb;
  logic [DW-1:0] r_deb_cnt [4];

  // Filtered bit follows the raw bit only once it has differed for DEB_CYCLES clocks in a row.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_deb <= '0;
      for (int i = 0; i < 4; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          r_deb[i]     <= btn[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end
  assign w_btn = r_deb;
`else
  assign w_btn = btn;
`endif

  state_t             r_state, w_state;
  phase_t             r_ph, w_ph;
  logic [31:0]        r_cnt, w_cnt;
  logic [3:0]         r_idx, w_idx;
  logic [3:0]         r_cursor, w_cursor;
  logic               r_view, w_view;
  logic [N_ITEMS-1:0] r_led, w_led;
  logic [3:0]         r_pend, w_pend;
  logic [3:0]         r_btn_prev;
  logic               r_rs, w_rs;
  logic               r_en, w_en;
  logic [7:0]         r_data, w_data;

  logic               w_event;
  logic               w_ld;
  logic               w_ld_init;
  logic [3:0]         w_ld_idx;
  logic [31:0]        w_wait;
  logic [N_ITEMS-1:0] w_mask;

  // Redraw is 14 bytes: clear, "LEDn" plus mode mark, line-2 address, 7-char LED status.
  function automatic logic [8:0] seq_byte(input logic init, input logic [3:0] idx,
                                          input logic [3:0] cur, input logic view,
                                          input logic on);
    logic [55:0] s;
    s = on ? STR_ON : STR_OFF;
    seq_byte = 9'h000;
    if (init) begin
      case (idx)
        4'd0, 4'd1: seq_byte = 9'h038;
        4'd2:       seq_byte = 9'h00C;
        default:    seq_byte = 9'h006;
      endcase
    end else begin
      case (idx)
        4'd0:    seq_byte = 9'h001;
        4'd1:    seq_byte = {1'b1, 8'h4C};
        4'd2:    seq_byte = {1'b1, 8'h45};
        4'd3:    seq_byte = {1'b1, 8'h44};
        4'd4:    seq_byte = {1'b1, 8'h31 + {4'h0, cur}};
        4'd5:    seq_byte = {1'b1, view ? 8'h2A : 8'h20};
        4'd6:    seq_byte = 9'h0C0;
        default: seq_byte = {1'b1, 8'(s >> (6'd8 * (6'd13 - {2'b00, idx})))};
      endcase
    end
  endfunction

  assign w_event = $onehot(w_btn) && (r_btn_prev == 4'b0000);
  assign w_mask  = N_ITEMS'(1) << r_cursor;
  assign w_wait  = (!r_rs && r_data == 8'h01) ? CLR_WAIT : CMD_WAIT;

  always_comb begin
    w_state   = r_state;
    w_ph      = r_ph;
    w_cnt     = r_cnt;
    w_idx     = r_idx;
    w_cursor  = r_cursor;
    w_view    = r_view;
    w_led     = r_led;
    w_pend    = r_pend;
    w_rs      = r_rs;
    w_en      = r_en;
    w_data    = r_data;
    w_ld      = 1'b0;
    w_ld_init = 1'b0;
    w_ld_idx  = 4'd0;

    if (r_state == S_IDLE && r_pend != 4'b0000) begin
      w_pend = w_event ? w_btn : 4'b0000;
    end else if (w_event && r_pend == 4'b0000) begin
      w_pend = w_btn;
    end

    case (r_state)
      S_PWR: begin
        if (r_cnt == PWRUP_WAIT - 1) begin
          w_ld      = 1'b1;
          w_ld_init = 1'b1;
          w_state   = S_INIT;
        end else begin
          w_cnt = r_cnt + 1;
        end
      end
      S_IDLE: begin
        case (r_pend)
          4'b1000: if (!r_view) begin
            w_cursor = (r_cursor == 4'd0) ? 4'(N_ITEMS - 1) : r_cursor - 4'd1;
            w_ld     = 1'b1;
          end
          4'b0100: if (!r_view) begin
            w_cursor = (r_cursor == 4'(N_ITEMS - 1)) ? 4'd0 : r_cursor + 4'd1;
            w_ld     = 1'b1;
          end
          4'b0010: begin
            if (r_view) w_led = r_led ^ w_mask;
            else        w_view = 1'b1;
            w_ld = 1'b1;
          end
          4'b0001: if (r_view) begin
            w_view = 1'b0;
            w_ld   = 1'b1;
          end
          default: ;
        endcase
        if (w_ld) w_state = S_REDRAW;
      end
      default: begin
        case (r_ph)
          PH_SETUP: begin
            w_en  = 1'b1;
            w_ph  = PH_EN;
            w_cnt = '0;
          end
          PH_EN: begin
            if (r_cnt == EN_CYCLES - 1) begin
              w_en  = 1'b0;
              w_ph  = PH_WAIT;
              w_cnt = '0;
            end else begin
              w_cnt = r_cnt + 1;
            end
          end
          default: begin
            if (r_cnt == w_wait - 1) begin
              if (r_state == S_INIT) begin
                w_ld = 1'b1;
                if (r_idx == LAST_CMD) begin
                  w_state = S_REDRAW;
                end else begin
                  w_ld_init = 1'b1;
                  w_ld_idx  = r_idx + 4'd1;
                end
              end else if (r_idx == LAST_RD) begin
                w_state = S_IDLE;
                w_cnt   = '0;
              end else begin
                w_ld     = 1'b1;
                w_ld_idx = r_idx + 4'd1;
              end
            end else begin
              w_cnt = r_cnt + 1;
            end
          end
        endcase
      end
    endcase

    // Byte 0 of a redraw is the clear command, so the pre-event cursor/mode used here never shows.
    if (w_ld) begin
      {w_rs, w_data} = seq_byte(w_ld_init, w_ld_idx, r_cursor, r_view, |(r_led & w_mask));
      w_en  = 1'b0;
      w_ph  = PH_SETUP;
      w_cnt = '0;
      w_idx = w_ld_idx;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_PWR;
      r_ph       <= PH_SETUP;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_cursor   <= '0;
      r_view     <= 1'b0;
      r_led      <= '0;
      r_pend     <= '0;
      r_btn_prev <= '0;
      r_rs       <= 1'b0;
      r_en       <= 1'b0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state;
      r_ph       <= w_ph;
      r_cnt      <= w_cnt;
      r_idx      <= w_idx;
      r_cursor   <= w_cursor;
      r_view     <= w_view;
      r_led      <= w_led;
      r_pend     <= w_pend;
      r_btn_prev <= w_btn;
      r_rs       <= w_rs;
      r_en       <= w_en;
      r_data     <= w_data;
    end
  end

  assign led_state = r_led;
  assign busy      = (r_state != S_IDLE);
  assign LCD_RS    = r_rs;
  assign LCD_EN    = r_en;
  assign LCD_RW    = 1'b0;
  assign LCD_DATA  = r_data;

endmodule
